// File: rtl/sar_search_if.sv
// Magnitude-compare handshake between the SAR initiator (master) and an
// external comparator (slave).
interface sar_search_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] guess;
  logic             guess_valid;
  logic             cmp_valid;
  logic             cmp_lt;
  logic             cmp_eq;
  logic             cmp_gt;

  modport master (
    output guess, guess_valid,
    input  cmp_valid, cmp_lt, cmp_eq, cmp_gt
  );

  modport slave (
    input  guess, guess_valid,
    output cmp_valid, cmp_lt, cmp_eq, cmp_gt
  );
endinterface

// File: rtl/sar_search.sv
// Successive-approximation search engine: finds an unknown target MSB-first by
// querying an external comparator once per bit.
module sar_search #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  sar_search_if.master               cmp,
  output logic                       busy,
  output logic                       done,
  output logic [WIDTH-1:0]           result,
  output logic                       hit,
  output logic                       err,
  output logic [$clog2(WIDTH+1)-1:0] steps
);

  localparam int SW = $clog2(WIDTH + 1);
  localparam int IW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, QUERY, FIN} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] trial, trial_n, result_n, upd;
  logic [IW-1:0]    idx, idx_n;
  logic [SW-1:0]    steps_n;
  logic             hit_n, err_n;
  logic             fire, onehot;

  assign busy            = (state == QUERY);
  assign done            = (state == FIN);
  assign cmp.guess_valid = busy;
  assign cmp.guess       = busy ? trial : '0;
  assign fire            = busy && cmp.cmp_valid;
  assign onehot          = $onehot({cmp.cmp_lt, cmp.cmp_eq, cmp.cmp_gt});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      trial  <= '0;
      idx    <= '0;
      result <= '0;
      hit    <= 1'b0;
      err    <= 1'b0;
      steps  <= '0;
    end else begin
      state  <= state_n;
      trial  <= trial_n;
      idx    <= idx_n;
      result <= result_n;
      hit    <= hit_n;
      err    <= err_n;
      steps  <= steps_n;
    end
  end

  always_comb begin
    state_n  = state;
    trial_n  = trial;
    idx_n    = idx;
    result_n = result;
    hit_n    = hit;
    err_n    = err;
    steps_n  = steps;
    upd      = trial;
    case (state)
      IDLE: begin
        if (start) begin
          trial_n            = '0;
          trial_n[WIDTH-1]   = 1'b1;
          idx_n              = IW'(WIDTH - 1);
          steps_n            = '0;
          hit_n              = 1'b0;
          err_n              = 1'b0;
          state_n            = QUERY;
        end
      end
      QUERY: begin
        if (fire) begin
          steps_n = steps + SW'(1);
          if (!onehot) begin
            result_n = trial;
            err_n    = 1'b1;
            state_n  = FIN;
          end else if (cmp.cmp_eq) begin
            result_n = trial;
            hit_n    = 1'b1;
            state_n  = FIN;
          end else begin
            // gt clears the bit under test; lt keeps it
            if (cmp.cmp_gt) upd[idx] = 1'b0;
            if (idx == '0) begin
              result_n = upd;
              hit_n    = 1'b0;
              state_n  = FIN;
            end else begin
              idx_n        = idx - IW'(1);
              upd[idx_n]   = 1'b1;
              trial_n      = upd;
            end
          end
        end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sar_search.sv
// Bench for sar_search: fixed vector table, reset/idle corner sequences and
// randomized searches against an arithmetic binary-search reference.
module tb_sar_search;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         busy, done, hit, err;
  logic [W-1:0] result;
  logic [3:0]   steps;

  sar_search_if #(.WIDTH(W)) sif ();

  sar_search #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .cmp    (sif.master),
    .busy   (busy),
    .done   (done),
    .result (result),
    .hit    (hit),
    .err    (err),
    .steps  (steps)
  );

  always #5 clk = ~clk;

  int   target = 0;
  int   wait_cycles = 0;
  int   bad_mode = 0;
  int   bad_step = 0;
  logic force_cmp = 1'b0;
  int   wait_cnt, hs_cnt;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_res = '0;

  // Comparator responder: combinational verdict after wait_cycles of holding.
  always_comb begin
    sif.cmp_valid = force_cmp || (sif.guess_valid && wait_cnt >= wait_cycles);
    sif.cmp_lt    = force_cmp || (int'(sif.guess) < target);
    sif.cmp_eq    = !force_cmp && (int'(sif.guess) == target);
    sif.cmp_gt    = !force_cmp && (int'(sif.guess) > target);
    if (!force_cmp && bad_step != 0 && hs_cnt == bad_step - 1) begin
      sif.cmp_lt = (bad_mode == 1);
      sif.cmp_eq = 1'b0;
      sif.cmp_gt = (bad_mode == 1);
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 0;
      hs_cnt   <= 0;
    end else begin
      if (sif.guess_valid && sif.cmp_valid) begin
        wait_cnt <= 0;
        hs_cnt   <= hs_cnt + 1;
      end else if (sif.guess_valid) begin
        wait_cnt <= wait_cnt + 1;
      end
      if (done) hs_cnt <= 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: bit-by-bit binary search with plain arithmetic.
  task automatic model(input int t, input int bs, output int r, output int h,
                       output int e, output int s);
    int acc, g;
    exp_q.delete();
    acc = 0; r = 0; h = 0; e = 0; s = 0;
    for (int b = W - 1; b >= 0; b--) begin
      g = acc + (1 << b);
      exp_q.push_back(W'(g));
      s++;
      if (s == bs) begin e = 1; r = g; return; end
      if (g == t)  begin h = 1; r = g; return; end
      if (g < t) acc = g;
    end
    r = acc;
  endtask

  task automatic run_search(input string tag, input int t, input int wt, input int bm,
                            input int bs, input int ms, input logic [W-1:0] prev_res,
                            input int er, input int eh, input int ee, input int es);
    logic [W-1:0] got_q[$];
    logic [W-1:0] prev_g;
    logic         prev_wait, stable;
    int           cyc, mr, mh, me, mss, n;
    target = t; wait_cycles = wt; bad_mode = bm; bad_step = bs;
    model(t, bs, mr, mh, me, mss);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    check({tag, "_start_busy"}, busy, 1);
    check({tag, "_start_steps"}, steps, 0);
    check({tag, "_start_hit"}, hit, 0);
    check({tag, "_start_err"}, err, 0);
    check({tag, "_start_result_held"}, result, prev_res);
    stable = 1'b1;
    prev_wait = 1'b0;
    prev_g = '0;
    while (!done && cyc < 1000) begin
      if (prev_wait && sif.guess !== prev_g) stable = 1'b0;
      prev_wait = sif.guess_valid && !sif.cmp_valid;
      prev_g = sif.guess;
      if (sif.guess_valid && sif.cmp_valid) got_q.push_back(sif.guess);
      start = (ms != 0 && cyc >= 4 && cyc <= 6);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check({tag, "_done"}, done, 1);
    check({tag, "_latency"}, cyc, (wt + 1) * es + 1);
    check({tag, "_result"}, result, er);
    check({tag, "_hit"}, hit, eh);
    check({tag, "_err"}, err, ee);
    check({tag, "_steps"}, steps, es);
    check({tag, "_fin_busy"}, busy, 0);
    check({tag, "_fin_gvalid"}, sif.guess_valid, 0);
    check({tag, "_guess_stable"}, stable, 1);
    check({tag, "_nguesses"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_guess%0d", tag, i), got_q[i], exp_q[i]);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_result_hold"}, result, er);
    check({tag, "_hit_hold"}, hit, eh);
  endtask

  typedef struct {
    int t; int wt; int bm; int bs; int ms;
    int er; int eh; int ee; int es;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int cyc, r, h, e, s, t, wt, bm, bs, ms;
    tbl[0] = '{t: 'hA5, wt: 0, bm: 0, bs: 0, ms: 0, er: 'hA5, eh: 1, ee: 0, es: 8};
    tbl[1] = '{t: 'h80, wt: 0, bm: 0, bs: 0, ms: 0, er: 'h80, eh: 1, ee: 0, es: 1};
    tbl[2] = '{t: 'h00, wt: 0, bm: 0, bs: 0, ms: 0, er: 'h00, eh: 0, ee: 0, es: 8};
    tbl[3] = '{t: 'h3C, wt: 3, bm: 0, bs: 0, ms: 1, er: 'h3C, eh: 1, ee: 0, es: 6};
    tbl[4] = '{t: 'hA5, wt: 0, bm: 1, bs: 3, ms: 0, er: 'hA0, eh: 0, ee: 1, es: 3};
    tbl[5] = '{t: 'h5A, wt: 1, bm: 2, bs: 1, ms: 0, er: 'h80, eh: 0, ee: 1, es: 1};
    tbl[6] = '{t: 'h01, wt: 2, bm: 0, bs: 0, ms: 0, er: 'h01, eh: 1, ee: 0, es: 8};

    #3;
    check("rst_guess", sif.guess, 0);
    check("rst_gvalid", sif.guess_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_hit", hit, 0);
    check("rst_err", err, 0);
    check("rst_steps", steps, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_search($sformatf("vec%0d", i), tbl[i].t, tbl[i].wt, tbl[i].bm, tbl[i].bs,
                 tbl[i].ms, last_res, tbl[i].er, tbl[i].eh, tbl[i].ee, tbl[i].es);
      last_res = W'(tbl[i].er);
    end
    bad_step = 0;

    // Verdict lines toggling while idle must not disturb anything.
    force_cmp = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_result", result, last_res);
    check("idle_steps", steps, 8);
    force_cmp = 1'b0;

    // Reset during the fourth query.
    target = 'h5A; wait_cycles = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (hs_cnt < 3 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_mid_reach_q4", hs_cnt, 3);
    check("rst_mid_busy_before", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_guess", sif.guess, 0);
    check("rst_mid_gvalid", sif.guess_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_result", result, 0);
    check("rst_mid_hit", hit, 0);
    check("rst_mid_err", err, 0);
    check("rst_mid_steps", steps, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst_mid_nodone%0d", i), done, 0);
    end
    last_res = '0;
    run_search("after_rst_ff", 'hFF, 0, 0, 0, 0, last_res, 'hFF, 1, 0, 8);
    last_res = 8'hFF;

    for (int i = 0; i < 25; i++) begin
      t  = int'($urandom_range(0, 255));
      wt = int'($urandom_range(0, 2));
      ms = int'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        bm = int'($urandom_range(1, 2));
        bs = int'($urandom_range(1, 8));
      end else begin
        bm = 0;
        bs = 0;
      end
      model(t, bs, r, h, e, s);
      run_search($sformatf("rnd%0d", i), t, wt, bm, bs, ms, last_res, r, h, e, s);
      last_res = W'(r);
    end
    bad_step = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
